// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder: fixed-latency RV32I data-memory responder with fault |
// | detection.  Revision: 1.0                                            |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int         c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] c_LAT   = 3'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [2:0]    r_cnt;
  logic [2:0]    w_nextCnt;
  logic          w_access;

  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic          r_write;

  logic          r_rspValid;
  logic [31:0]   r_rspRdata;
  logic          r_rspErr;

  logic [31:0]   r_mem [DEPTH_WORDS];

  // With zero latency the access happens on the accept edge, so the live
  // request is used; otherwise the values captured at acceptance are used.
  logic [31:0]        w_accAddr;
  logic [31:0]        w_accWdata;
  logic [2:0]         w_accFunct3;
  logic               w_accWrite;
  logic [1:0]         w_lane;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_oob;
  logic               w_fault;
  logic [3:0]         w_be;
  logic [31:0]        w_wdAligned;
  logic [31:0]        w_rdWord;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_loadData;
  logic               w_doWrite;

  assign w_accAddr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_accWdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_accFunct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_accWrite  = (r_state == IDLE) ? req_write  : r_write;

  assign w_lane   = w_accAddr[1:0];
  assign w_idx    = w_accAddr[c_IDX_W+1:2];
  assign w_oob    = ({2'b00, w_accAddr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_rdWord = r_mem[w_idx];
  assign w_byte   = w_rdWord[{w_lane, 3'b000} +: 8];
  assign w_half   = w_rdWord[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_fault     = 1'b0;
    w_be        = 4'b0000;
    w_wdAligned = w_accWdata;
    w_loadData  = 32'h0;
    case (w_accFunct3)
      3'b000, 3'b100: begin
        w_be        = 4'b0001 << w_lane;
        w_wdAligned = {4{w_accWdata[7:0]}};
        w_loadData  = w_accFunct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      3'b001, 3'b101: begin
        w_fault     = w_lane[0];
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdAligned = {2{w_accWdata[15:0]}};
        w_loadData  = w_accFunct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      3'b010: begin
        w_fault    = (w_lane != 2'b00);
        w_be       = 4'b1111;
        w_loadData = w_rdWord;
      end
      default: w_fault = 1'b1;
    endcase
    if (w_oob) begin
      w_fault = 1'b1;
    end
    if (w_fault || w_accWrite) begin
      w_loadData = 32'h0;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (c_LAT == 3'd0) begin
            w_nextState = RESP;
            w_nextCnt   = 3'd0;
            w_access    = 1'b1;
          end else begin
            w_nextState = WAIT;
            w_nextCnt   = c_LAT;
          end
        end
      end
      WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_nextState = RESP;
          w_nextCnt   = 3'd0;
          w_access    = 1'b1;
        end else begin
          w_nextCnt = r_cnt - 3'd1;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 3'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_funct3   <= 3'd0;
      r_write    <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= 32'h0;
      r_rspErr   <= 1'b0;
    end else begin
      r_cnt <= w_nextCnt;
      if (r_state == IDLE && req_valid) begin
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
        r_write  <= req_write;
      end
      r_rspValid <= w_access;
      r_rspErr   <= w_access && w_fault;
      r_rspRdata <= w_access ? w_loadData : 32'h0;
    end
  end

  // Storage has no reset; gating with reset keeps a zero-latency request
  // presented during reset from writing.
  assign w_doWrite = reset && w_access && w_accWrite && !w_fault;

  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdAligned[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign stall     = reset && (((r_state == IDLE) && req_valid) || (r_state == WAIT));
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder: directed checks for LATENCY=2 and LATENCY=0.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        reqValid [2];
  logic        reqWrite [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic [2:0]  reqF3    [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic [31:0] rspRdata [2];
  logic        rspErr   [2];
  logic        stall    [2];

  int nVec = 0;
  int nErr = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]), .req_addr(reqAddr[0]),
    .req_wdata(reqWdata[0]), .req_funct3(reqF3[0]), .req_ready(reqReady[0]),
    .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dutZero (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]), .req_addr(reqAddr[1]),
    .req_wdata(reqWdata[1]), .req_funct3(reqF3[1]), .req_ready(reqReady[1]),
    .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]),
    .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request, scrambles the inputs after acceptance, and waits
  // (bounded) for the response strobe.  lat counts cycles from accept.
  task automatic doReq(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    chk("ready", {31'h0, reqReady[k]}, 32'h1);
    reqValid[k] = 1'b1;
    reqWrite[k] = wr;
    reqAddr[k]  = addr;
    reqWdata[k] = wd;
    reqF3[k]    = f3;
    @(negedge clk);
    reqValid[k] = 1'b0;
    reqWrite[k] = ~wr;
    reqAddr[k]  = $urandom;
    reqWdata[k] = $urandom;
    reqF3[k]    = 3'($urandom);
    lat = 1;
    while (!rspValid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = rspRdata[k];
    err = rspErr[k];
  endtask

  task automatic xact(input string tag, input int k, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] expD, input logic expE);
    logic [31:0] rd;
    logic        err;
    int          lat;
    doReq(k, wr, addr, wd, f3, rd, err, lat);
    chk({tag, "/lat"}, 32'(lat), (k == 0) ? 32'd3 : 32'd1);
    chk({tag, "/data"}, rd, expD);
    chk({tag, "/err"}, {31'h0, err}, {31'h0, expE});
  endtask

  logic [7:0] rdyBits, stallBits, vldBits;
  logic       sawRsp;

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      reqValid[k] = 1'b0; reqWrite[k] = 1'b0; reqAddr[k] = '0;
      reqWdata[k] = '0;   reqF3[k] = 3'b010;
    end
    reqValid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst/stall", {31'h0, stall[0]}, 32'h0);
    chk("rst/out", {rspValid[0], rspErr[0], rspRdata[0][29:0]}, 32'h0);
    reqValid[0] = 1'b0;
    reset = 1'b1;

    // Basic word store/load and sub-word access
    xact("sw10",   0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
    xact("lw10",   0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
    xact("sb13",   0, 1'b1, 32'h13, 32'h12345680, 3'b000, 32'h0,        1'b0);
    xact("lb13",   0, 1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
    xact("lbu13",  0, 1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0);
    xact("lw10b",  0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0);
    xact("lh11",   0, 1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1);
    @(negedge clk);
    chk("errClr", {rspErr[0], rspRdata[0][30:0]}, 32'h0);
    xact("sw12",   0, 1'b1, 32'h12, 32'h01020304, 3'b010, 32'h0,        1'b1);
    xact("lw10c",  0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0);
    xact("lb12",   0, 1'b0, 32'h12, 32'h0,        3'b000, 32'hFFFFFFAD, 1'b0);
    xact("lhu10",  0, 1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 1'b0);
    xact("lh10",   0, 1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0);
    xact("sw14",   0, 1'b1, 32'h14, 32'h11223344, 3'b010, 32'h0,        1'b0);
    xact("sh16",   0, 1'b1, 32'h16, 32'hAAAA8001, 3'b001, 32'h0,        1'b0);
    xact("lh16",   0, 1'b0, 32'h16, 32'h0,        3'b001, 32'hFFFF8001, 1'b0);
    xact("lhu16",  0, 1'b0, 32'h16, 32'h0,        3'b101, 32'h00008001, 1'b0);
    xact("f3st7",  0, 1'b1, 32'h14, 32'h0,        3'b111, 32'h0,        1'b1);
    xact("lw14",   0, 1'b0, 32'h14, 32'h0,        3'b010, 32'h80013344, 1'b0);
    xact("f3ld3",  0, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0,        1'b1);
    xact("sw00",   0, 1'b1, 32'h0,  32'h00000055, 3'b010, 32'h0,        1'b0);
    xact("swOob",  0, 1'b1, 32'h1000, 32'h99999999, 3'b010, 32'h0,      1'b1);
    xact("lw00",   0, 1'b0, 32'h0,  32'h0,        3'b010, 32'h00000055, 1'b0);
    xact("lwOob",  0, 1'b0, 32'h1000, 32'h0,      3'b010, 32'h0,        1'b1);

    // Back-to-back: one accept every 4 cycles, stall low only in RESP
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b0; reqAddr[0] = 32'h10; reqF3[0] = 3'b010;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      rdyBits[i]   = reqReady[0];
      stallBits[i] = stall[0];
      vldBits[i]   = rspValid[0];
    end
    reqValid[0] = 1'b0;
    chk("b2b/ready", {24'h0, rdyBits},   32'h11);
    chk("b2b/stall", {24'h0, stallBits}, 32'h77);
    chk("b2b/valid", {24'h0, vldBits},   32'h88);

    // Reset during WAIT of a store aborts it
    xact("sw20",   0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddr[0] = 32'h20;
    reqWdata[0] = 32'h12345678; reqF3[0] = 3'b010;
    @(negedge clk);
    reqValid[0] = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("abort/out", {rspValid[0], stall[0], rspErr[0], rspRdata[0][28:0]}, 32'h0);
    sawRsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawRsp |= rspValid[0];
    end
    chk("abort/noRsp", {31'h0, sawRsp}, 32'h0);
    reset = 1'b1;
    xact("lw20",   0, 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

    // Zero-latency instance, 16 words deep
    xact("z/sw00", 1, 1'b1, 32'h0,  32'hA5A5A5A5, 3'b010, 32'h0,        1'b0);
    xact("z/sw3c", 1, 1'b1, 32'h3C, 32'h01020304, 3'b010, 32'h0,        1'b0);
    xact("z/swOob",1, 1'b1, 32'h40, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1);
    xact("z/lwOob",1, 1'b0, 32'h40, 32'h0,        3'b010, 32'h0,        1'b1);
    xact("z/lw00", 1, 1'b0, 32'h0,  32'h0,        3'b010, 32'hA5A5A5A5, 1'b0);
    xact("z/lw3c", 1, 1'b0, 32'h3C, 32'h0,        3'b010, 32'h01020304, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
